// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution: holds fetch-time predictions in an in-order FIFO,
// checks each against the real outcome, and drives predictor/BTB updates and redirects.
module branch_resolve_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  fetch_valid,
    output logic                  fetch_ready,
    input  logic [DATA_WIDTH-1:0] fetch_pc,
    input  logic                  fetch_hit,
    input  logic                  fetch_pred,
    input  logic [DATA_WIDTH-1:0] fetch_target,
    input  logic                  resolve_valid,
    input  logic                  resolve_taken,
    input  logic [DATA_WIDTH-1:0] resolve_target,
    input  logic                  flush,
    output logic                  update_predictor,
    output logic                  update_btb,
    output logic                  actually_taken,
    output logic [DATA_WIDTH-1:0] resolved_pc,
    output logic [DATA_WIDTH-1:0] resolved_pc_target,
    output logic                  mispredict,
    output logic [DATA_WIDTH-1:0] redirect_pc,
    output logic [DATA_WIDTH-1:0] branch_count,
    output logic [DATA_WIDTH-1:0] mispredict_count
);
    // Handshake: an enqueue happens on a cycle where fetch_valid and fetch_ready are both 1;
    // fetch_ready is decoded from the registered occupancy only.
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_WIDTH-1:0] pc_mem     [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] target_mem [FIFO_DEPTH];
    logic                  hit_mem    [FIFO_DEPTH];
    logic                  pred_mem   [FIFO_DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;

    logic                  enq;
    logic                  res;
    logic                  eff_taken;
    logic                  mis;
    logic [DATA_WIDTH-1:0] head_pc;
    logic [DATA_WIDTH-1:0] head_target;
    logic [DATA_WIDTH-1:0] redirect_next;

    assign fetch_ready = (count != CW'(FIFO_DEPTH));
    assign enq         = fetch_valid & fetch_ready;
    assign res         = resolve_valid & (count != '0) & ~flush;

    assign head_pc     = pc_mem[head];
    assign head_target = target_mem[head];

    // The fetch target only steers fetch on a BTB hit, so a miss always predicts fall-through.
    assign eff_taken = hit_mem[head] & pred_mem[head];
    assign mis = res & ((eff_taken != resolve_taken) |
                        (eff_taken & resolve_taken & (head_target != resolve_target)));
    assign redirect_next = resolve_taken ? resolve_target : head_pc + DATA_WIDTH'(4);

    // Payload storage needs no reset: validity lives entirely in the pointers and count.
    always_ff @(posedge clk) begin
        if (enq) begin
            pc_mem[tail]     <= fetch_pc;
            target_mem[tail] <= fetch_target;
            hit_mem[tail]    <= fetch_hit;
            pred_mem[tail]   <= fetch_pred;
        end
    end

    // A mispredict squashes everything behind it, including a same-cycle wrong-path enqueue.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush || mis) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) tail <= tail + PW'(1);
            if (res) head <= head + PW'(1);
            if (enq && !res) begin
                count <= count + CW'(1);
            end else if (!enq && res) begin
                count <= count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            update_predictor   <= 1'b0;
            update_btb         <= 1'b0;
            mispredict         <= 1'b0;
            actually_taken     <= 1'b0;
            resolved_pc        <= '0;
            resolved_pc_target <= '0;
            redirect_pc        <= '0;
            branch_count       <= '0;
            mispredict_count   <= '0;
        end else begin
            update_predictor <= res;
            update_btb       <= res & resolve_taken;
            mispredict       <= mis;
            if (res) begin
                actually_taken     <= resolve_taken;
                resolved_pc        <= head_pc;
                resolved_pc_target <= resolve_target;
                redirect_pc        <= redirect_next;
                if (branch_count != '1) branch_count <= branch_count + DATA_WIDTH'(1);
            end
            if (mis && mispredict_count != '1) begin
                mispredict_count <= mispredict_count + DATA_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: a vector table plus directed multi-cycle sequences,
// checked through an expected-result queue drained by a negedge monitor.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        fetch_valid = 1'b0, fetch_ready, fetch_hit = 1'b0, fetch_pred = 1'b0;
    logic [31:0] fetch_pc = '0, fetch_target = '0;
    logic        resolve_valid = 1'b0, resolve_taken = 1'b0, flush = 1'b0;
    logic [31:0] resolve_target = '0;
    logic        update_predictor, update_btb, actually_taken, mispredict;
    logic [31:0] resolved_pc, resolved_pc_target, redirect_pc, branch_count, mispredict_count;

    // Narrow instance so both counters can be driven all the way to saturation.
    logic       s_fetch_valid = 1'b0, s_fetch_ready, s_resolve_valid = 1'b0;
    logic [3:0] s_fetch_pc = '0, s_fetch_target = '0, s_resolve_target = '0;
    logic       s_fetch_hit = 1'b0, s_fetch_pred = 1'b0, s_resolve_taken = 1'b0;
    logic       s_upd_pred, s_upd_btb, s_act_taken, s_mispredict;
    logic [3:0] s_resolved_pc, s_resolved_tgt, s_redirect_pc, s_branch_count, s_mis_count;

    branch_resolve_unit dut (
        .clk(clk), .rstn(rstn),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_pc(fetch_pc),
        .fetch_hit(fetch_hit), .fetch_pred(fetch_pred), .fetch_target(fetch_target),
        .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
        .resolve_target(resolve_target), .flush(flush),
        .update_predictor(update_predictor), .update_btb(update_btb),
        .actually_taken(actually_taken), .resolved_pc(resolved_pc),
        .resolved_pc_target(resolved_pc_target), .mispredict(mispredict),
        .redirect_pc(redirect_pc), .branch_count(branch_count),
        .mispredict_count(mispredict_count)
    );

    branch_resolve_unit #(.DATA_WIDTH(4), .FIFO_DEPTH(2)) dut_small (
        .clk(clk), .rstn(rstn),
        .fetch_valid(s_fetch_valid), .fetch_ready(s_fetch_ready), .fetch_pc(s_fetch_pc),
        .fetch_hit(s_fetch_hit), .fetch_pred(s_fetch_pred), .fetch_target(s_fetch_target),
        .resolve_valid(s_resolve_valid), .resolve_taken(s_resolve_taken),
        .resolve_target(s_resolve_target), .flush(1'b0),
        .update_predictor(s_upd_pred), .update_btb(s_upd_btb),
        .actually_taken(s_act_taken), .resolved_pc(s_resolved_pc),
        .resolved_pc_target(s_resolved_tgt), .mispredict(s_mispredict),
        .redirect_pc(s_redirect_pc), .branch_count(s_branch_count),
        .mispredict_count(s_mis_count)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] rtgt;
        logic        mis;
        logic [31:0] redir;
        int          due;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] exp_bc = '0;
    logic [31:0] exp_mc = '0;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        logic pulse_due;
        exp_t e;
        pulse_due = (exp_q.size() > 0) && (exp_q[0].due == cyc);
        check("update_predictor", {31'b0, update_predictor}, {31'b0, pulse_due});
        if (pulse_due) begin
            e = exp_q.pop_front();
            check("update_btb", {31'b0, update_btb}, {31'b0, e.taken});
            check("actually_taken", {31'b0, actually_taken}, {31'b0, e.taken});
            check("resolved_pc", resolved_pc, e.pc);
            check("resolved_pc_target", resolved_pc_target, e.rtgt);
            check("mispredict", {31'b0, mispredict}, {31'b0, e.mis});
            check("redirect_pc", redirect_pc, e.redir);
            exp_bc = exp_bc + 1;
            if (e.mis) exp_mc = exp_mc + 1;
        end else begin
            check("idle_mispredict", {31'b0, mispredict}, 32'h0);
            check("idle_update_btb", {31'b0, update_btb}, 32'h0);
        end
        check("branch_count", branch_count, exp_bc);
        check("mispredict_count", mispredict_count, exp_mc);
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
        fetch_valid = 1'b0;
        resolve_valid = 1'b0;
        flush = 1'b0;
        s_fetch_valid = 1'b0;
        s_resolve_valid = 1'b0;
    endtask

    task automatic enq(input logic [31:0] pc, input logic hit, input logic pred,
                       input logic [31:0] tgt);
        fetch_valid = 1'b1;
        fetch_pc = pc;
        fetch_hit = hit;
        fetch_pred = pred;
        fetch_target = tgt;
    endtask

    task automatic res(input logic taken, input logic [31:0] rtgt);
        resolve_valid = 1'b1;
        resolve_taken = taken;
        resolve_target = rtgt;
    endtask

    task automatic expect_res(input logic [31:0] pc, input logic taken, input logic [31:0] rtgt,
                              input logic mis, input logic [31:0] redir);
        exp_t e;
        e.pc = pc; e.taken = taken; e.rtgt = rtgt; e.mis = mis; e.redir = redir;
        e.due = cyc + 1;
        exp_q.push_back(e);
    endtask

    // ---------------- stimulus ----------------
    typedef struct {
        logic [31:0] pc;
        logic        hit;
        logic        pred;
        logic [31:0] tgt;
        logic        taken;
        logic [31:0] rtgt;
        logic        mis;
        logic [31:0] redir;
    } vec_t;

    vec_t vecs[9];

    initial begin
        vecs[0] = '{32'h100, 1'b1, 1'b1, 32'h200, 1'b1, 32'h200, 1'b0, 32'h200};
        vecs[1] = '{32'h100, 1'b1, 1'b1, 32'h200, 1'b1, 32'h300, 1'b1, 32'h300};
        vecs[2] = '{32'h40, 1'b1, 1'b1, 32'h80, 1'b0, 32'h0, 1'b1, 32'h44};
        vecs[3] = '{32'h50, 1'b0, 1'b1, 32'h90, 1'b0, 32'h0, 1'b0, 32'h54};
        vecs[4] = '{32'h60, 1'b1, 1'b0, 32'h90, 1'b1, 32'hA0, 1'b1, 32'hA0};
        vecs[5] = '{32'h70, 1'b0, 1'b0, 32'h0, 1'b1, 32'h74, 1'b1, 32'h74};
        vecs[6] = '{32'hFFFF_FFFC, 1'b1, 1'b1, 32'h10, 1'b0, 32'h0, 1'b1, 32'h0};
        vecs[7] = '{32'h1000, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h1004};
        vecs[8] = '{32'h20, 1'b0, 1'b1, 32'h30, 1'b1, 32'h30, 1'b1, 32'h30};

        repeat (3) step();
        check("reset_fetch_ready", {31'b0, fetch_ready}, 32'h1);
        rstn = 1'b1;
        step();

        // table: one enqueue then its resolve
        for (int i = 0; i < 9; i++) begin
            enq(vecs[i].pc, vecs[i].hit, vecs[i].pred, vecs[i].tgt);
            step();
            res(vecs[i].taken, vecs[i].rtgt);
            expect_res(vecs[i].pc, vecs[i].taken, vecs[i].rtgt, vecs[i].mis, vecs[i].redir);
            step();
        end
        step();

        // not-taken mispredict with a same-cycle wrong-path enqueue
        enq(32'h40, 1'b1, 1'b1, 32'h80);
        step();
        res(1'b0, 32'h0);
        enq(32'h500, 1'b0, 1'b0, 32'h0);
        expect_res(32'h40, 1'b0, 32'h0, 1'b1, 32'h44);
        step();
        res(1'b0, 32'h0);  // FIFO must be empty: no pulse expected
        step();
        step();

        // fill to full, resolve at full, simultaneous enqueue+resolve at count 3
        for (int i = 1; i <= 4; i++) begin
            enq(32'h10 * i, 1'b0, 1'b0, 32'h0);
            step();
        end
        check("full_fetch_ready", {31'b0, fetch_ready}, 32'h0);
        enq(32'h99, 1'b1, 1'b1, 32'h0);
        step();
        check("full_ignore_ready", {31'b0, fetch_ready}, 32'h0);
        enq(32'h99, 1'b1, 1'b1, 32'h0);
        res(1'b0, 32'h0);
        expect_res(32'h10, 1'b0, 32'h0, 1'b0, 32'h14);
        step();
        check("count3_ready", {31'b0, fetch_ready}, 32'h1);
        enq(32'h50, 1'b0, 1'b0, 32'h0);
        res(1'b0, 32'h0);
        expect_res(32'h20, 1'b0, 32'h0, 1'b0, 32'h24);
        step();
        check("simul_ready", {31'b0, fetch_ready}, 32'h1);
        enq(32'h60, 1'b0, 1'b0, 32'h0);
        step();
        check("refill_ready", {31'b0, fetch_ready}, 32'h0);
        for (int i = 3; i <= 6; i++) begin
            res(1'b0, 32'h0);
            expect_res(32'h10 * i, 1'b0, 32'h0, 1'b0, 32'h10 * i + 32'h4);
            step();
        end
        res(1'b1, 32'h1);  // empty: ignored
        step();
        step();

        // external flush beats a same-cycle resolve and enqueue
        enq(32'h700, 1'b1, 1'b1, 32'h800);
        step();
        enq(32'h710, 1'b1, 1'b1, 32'h810);
        step();
        flush = 1'b1;
        res(1'b1, 32'h800);
        enq(32'h720, 1'b0, 1'b0, 32'h0);
        step();
        check("flush_ready", {31'b0, fetch_ready}, 32'h1);
        res(1'b1, 32'h810);
        step();
        enq(32'h730, 1'b0, 1'b0, 32'h0);
        step();
        res(1'b0, 32'h0);
        expect_res(32'h730, 1'b0, 32'h0, 1'b0, 32'h734);
        step();
        step();

        // asynchronous reset with three entries queued
        for (int i = 0; i < 3; i++) begin
            enq(32'h900 + 32'h10 * i, 1'b1, 1'b1, 32'hA00);
            step();
        end
        exp_q.delete();
        exp_bc = '0;
        exp_mc = '0;
        rstn = 1'b0;
        #1;
        check("rst_fetch_ready", {31'b0, fetch_ready}, 32'h1);
        check("rst_update_predictor", {31'b0, update_predictor}, 32'h0);
        check("rst_mispredict", {31'b0, mispredict}, 32'h0);
        check("rst_branch_count", branch_count, 32'h0);
        check("rst_mispredict_count", mispredict_count, 32'h0);
        check("rst_redirect_pc", redirect_pc, 32'h0);
        step();
        rstn = 1'b1;
        step();
        res(1'b1, 32'hA00);  // entries gone: no pulse
        step();
        enq(32'h40, 1'b0, 1'b0, 32'h0);
        step();
        res(1'b1, 32'h88);
        expect_res(32'h40, 1'b1, 32'h88, 1'b1, 32'h88);
        step();
        step();

        // saturation on the 4-bit instance; pc 0xC + 4 wraps to 0
        for (int i = 0; i < 17; i++) begin
            s_fetch_valid = 1'b1;
            s_fetch_pc = 4'hC;
            s_fetch_hit = 1'b1;
            s_fetch_pred = 1'b1;
            s_fetch_target = 4'h8;
            step();
            s_resolve_valid = 1'b1;
            s_resolve_taken = 1'b0;
            s_resolve_target = 4'h0;
            step();
            check("sat_mispredict", {31'b0, s_mispredict}, 32'h1);
            check("sat_redirect_wrap", {28'b0, s_redirect_pc}, 32'h0);
            check("sat_mis_count", {28'b0, s_mis_count}, (i + 1 > 15) ? 32'd15 : i + 1);
            check("sat_branch_count", {28'b0, s_branch_count}, (i + 1 > 15) ? 32'd15 : i + 1);
        end
        step();

        check("queue_drained", exp_q.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
